// File: rtl/compr_pkg.sv
// rtl/compr_pkg.sv - shared sizing helpers and segment field offsets for the compare tree
package compr_pkg;

    // The rule ID always occupies the low bits of a segment.
    localparam int ID_LSB = 0;

    // Ceiling log2; clog2(1) = 0 so a single segment needs no tree levels.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Priority sits directly above the rule ID.
    function automatic int prio_lsb(input int idwid);
        return idwid;
    endfunction

    // Match flag is the top bit of a segment.
    function automatic int match_bit(input int idwid, input int priwid);
        return idwid + priwid;
    endfunction

    // Number of live nodes entering tree level lvl.
    function automatic int level_nodes(input int nseg, input int lvl);
        return (nseg + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/compr_node.sv
// rtl/compr_node.sv - combinational two-segment compare, left operand wins every tie
module compr_node
    import compr_pkg::*;
#(
    parameter int IDWID    = 8,
    parameter int PRIWID   = 8,
    parameter int IXW      = 4,
    parameter int PRIO_MAX = 1,
    parameter int SEGW     = 1 + PRIWID + IDWID
) (
    input  logic [SEGW-1:0] i_Seg_A,
    input  logic [IXW-1:0]  i_Idx_A,
    input  logic [SEGW-1:0] i_Seg_B,
    input  logic [IXW-1:0]  i_Idx_B,
    output logic [SEGW-1:0] o_Seg,
    output logic [IXW-1:0]  o_Idx
);

    localparam int MATCH_BIT = match_bit(IDWID, PRIWID);
    localparam int PRIO_LSB  = prio_lsb(IDWID);

    logic              w_match_a;
    logic              w_match_b;
    logic [PRIWID-1:0] w_prio_a;
    logic [PRIWID-1:0] w_prio_b;
    logic              w_b_better;
    logic              w_pick_b;

    assign w_match_a = i_Seg_A[MATCH_BIT];
    assign w_match_b = i_Seg_B[MATCH_BIT];
    assign w_prio_a  = i_Seg_A[PRIO_LSB +: PRIWID];
    assign w_prio_b  = i_Seg_B[PRIO_LSB +: PRIWID];

    // Strict compare so equal priorities fall back to the left (lower index) operand.
    assign w_b_better = (PRIO_MAX != 0) ? (w_prio_b > w_prio_a) : (w_prio_b < w_prio_a);

    // Right wins only if it alone matches, or both match and it is strictly better.
    assign w_pick_b = (w_match_b && !w_match_a) || (w_match_a && w_match_b && w_b_better);

    assign o_Seg = w_pick_b ? i_Seg_B : i_Seg_A;
    assign o_Idx = w_pick_b ? i_Idx_B : i_Idx_A;

endmodule

// File: rtl/compr_tree_pipe.sv
// rtl/compr_tree_pipe.sv - registered binary reduction of NSEG match segments to one winner
module compr_tree_pipe
    import compr_pkg::*;
#(
    parameter int NSEG     = 13,
    parameter int IDWID    = 8,
    parameter int PRIWID   = 8,
    parameter int PRIO_MAX = 1,
    parameter int SEGW     = 1 + PRIWID + IDWID,
    parameter int IXW      = (clog2(NSEG) > 0) ? clog2(NSEG) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_Valid,
    input  logic                 i_Hold,
    input  logic [NSEG*SEGW-1:0] i_Seg_Vector,
    output logic                 o_Valid,
    output logic [SEGW-1:0]      o_Compare_Result,
    output logic [IXW-1:0]       o_Win_Index,
    output logic                 o_Hit
);

    localparam int L         = clog2(NSEG);
    localparam int MATCH_BIT = match_bit(IDWID, PRIWID);

    // Taps: the registered node set feeding each level; tap L is the final result.
    logic [SEGW-1:0] w_tap_seg [0:L][0:NSEG-1];
    logic [IXW-1:0]  w_tap_idx [0:L][0:NSEG-1];
    logic [L:0]      w_tap_vld;

    logic [SEGW-1:0] r_seg0 [0:NSEG-1];
    logic            r_vld0;

    // Stage 0: capture the raw segment vector and its valid unless the pipe is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld0 <= 1'b0;
            for (int k = 0; k < NSEG; k++) r_seg0[k] <= '0;
        end else if (!i_Hold) begin
            r_vld0 <= i_Valid;
            for (int k = 0; k < NSEG; k++) r_seg0[k] <= i_Seg_Vector[k*SEGW +: SEGW];
        end
    end

    assign w_tap_vld[0] = r_vld0;

    for (genvar k = 0; k < NSEG; k++) begin : g_tap0
        assign w_tap_seg[0][k] = r_seg0[k];
        assign w_tap_idx[0][k] = IXW'(k);
    end

    for (genvar lvl = 0; lvl < L; lvl++) begin : g_lvl
        localparam int NIN  = level_nodes(NSEG, lvl);
        localparam int NOUT = level_nodes(NSEG, lvl + 1);

        logic [SEGW-1:0] w_nxt_seg [0:NOUT-1];
        logic [IXW-1:0]  w_nxt_idx [0:NOUT-1];
        logic [SEGW-1:0] r_seg     [0:NOUT-1];
        logic [IXW-1:0]  r_idx     [0:NOUT-1];
        logic            r_vld;

        for (genvar j = 0; j < NOUT; j++) begin : g_node
            if (j < NIN / 2) begin : g_pair
                compr_node #(
                    .IDWID    (IDWID),
                    .PRIWID   (PRIWID),
                    .IXW      (IXW),
                    .PRIO_MAX (PRIO_MAX),
                    .SEGW     (SEGW)
                ) u_node (
                    .i_Seg_A (w_tap_seg[lvl][2*j]),
                    .i_Idx_A (w_tap_idx[lvl][2*j]),
                    .i_Seg_B (w_tap_seg[lvl][2*j+1]),
                    .i_Idx_B (w_tap_idx[lvl][2*j+1]),
                    .o_Seg   (w_nxt_seg[j]),
                    .o_Idx   (w_nxt_idx[j])
                );
            end else begin : g_pass
                // Unpaired last node is forwarded untouched rather than compared with itself.
                assign w_nxt_seg[j] = w_tap_seg[lvl][2*j];
                assign w_nxt_idx[j] = w_tap_idx[lvl][2*j];
            end
        end

        // Level register: advance this level's winners and valid unless held.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                for (int j = 0; j < NOUT; j++) begin
                    r_seg[j] <= '0;
                    r_idx[j] <= '0;
                end
            end else if (!i_Hold) begin
                r_vld <= w_tap_vld[lvl];
                for (int j = 0; j < NOUT; j++) begin
                    r_seg[j] <= w_nxt_seg[j];
                    r_idx[j] <= w_nxt_idx[j];
                end
            end
        end

        assign w_tap_vld[lvl+1] = r_vld;

        for (genvar j = 0; j < NSEG; j++) begin : g_tap
            if (j < NOUT) begin : g_live
                assign w_tap_seg[lvl+1][j] = r_seg[j];
                assign w_tap_idx[lvl+1][j] = r_idx[j];
            end else begin : g_dead
                assign w_tap_seg[lvl+1][j] = '0;
                assign w_tap_idx[lvl+1][j] = '0;
            end
        end
    end

    assign o_Valid          = w_tap_vld[L];
    assign o_Compare_Result = w_tap_seg[L][0];
    assign o_Win_Index      = w_tap_idx[L][0];
    assign o_Hit            = w_tap_vld[L] & w_tap_seg[L][0][MATCH_BIT];

endmodule

// File: tb/tb_compr_tree_pipe.sv
// tb/tb_compr_tree_pipe.sv - directed and reference-model bench for compr_tree_pipe
module tb_compr_tree_pipe;

    logic clk = 1'b0;
    logic rst;
    logic hold;

    logic         v13_valid, vm_valid, v1_valid, v17_valid;
    logic [220:0] v13_vec, vm_vec;
    logic [16:0]  v1_vec;
    logic [288:0] v17_vec;

    logic        o13_valid, o13_hit, om_valid, om_hit, o1_valid, o1_hit, o17_valid, o17_hit;
    logic [16:0] o13_res, om_res, o1_res, o17_res;
    logic [3:0]  o13_idx, om_idx;
    logic [0:0]  o1_idx;
    logic [4:0]  o17_idx;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    compr_tree_pipe #(.NSEG(13), .PRIO_MAX(1)) dut (
        .clk(clk), .rst(rst), .i_Valid(v13_valid), .i_Hold(hold), .i_Seg_Vector(v13_vec),
        .o_Valid(o13_valid), .o_Compare_Result(o13_res), .o_Win_Index(o13_idx), .o_Hit(o13_hit));

    compr_tree_pipe #(.NSEG(13), .PRIO_MAX(0)) dut_min (
        .clk(clk), .rst(rst), .i_Valid(vm_valid), .i_Hold(hold), .i_Seg_Vector(vm_vec),
        .o_Valid(om_valid), .o_Compare_Result(om_res), .o_Win_Index(om_idx), .o_Hit(om_hit));

    compr_tree_pipe #(.NSEG(1), .PRIO_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .i_Valid(v1_valid), .i_Hold(hold), .i_Seg_Vector(v1_vec),
        .o_Valid(o1_valid), .o_Compare_Result(o1_res), .o_Win_Index(o1_idx), .o_Hit(o1_hit));

    compr_tree_pipe #(.NSEG(17), .PRIO_MAX(1)) dut17 (
        .clk(clk), .rst(rst), .i_Valid(v17_valid), .i_Hold(hold), .i_Seg_Vector(v17_vec),
        .o_Valid(o17_valid), .o_Compare_Result(o17_res), .o_Win_Index(o17_idx), .o_Hit(o17_hit));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] seg(input logic m, input logic [7:0] p, input logic [7:0] id);
        return {m, p, id};
    endfunction

    // One search on both 13-segment instances; result must appear exactly 5 edges after capture.
    task automatic run13(input string tag, input logic [220:0] vmax, input logic [220:0] vmin,
                         input logic [16:0] ex_res, input logic [3:0] ex_idx,
                         input logic [16:0] em_res, input logic [3:0] em_idx);
        v13_vec = vmax; vm_vec = vmin; v13_valid = 1'b1; vm_valid = 1'b1;
        step();
        v13_valid = 1'b0; vm_valid = 1'b0;
        repeat (3) step();
        chk({tag, "_early"}, 64'(o13_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(o13_valid), 64'd1);
        chk({tag, "_res"},   64'(o13_res),   64'(ex_res));
        chk({tag, "_idx"},   64'(o13_idx),   64'(ex_idx));
        chk({tag, "_hit"},   64'(o13_hit),   64'(ex_res[16]));
        chk({tag, "_mvalid"}, 64'(om_valid), 64'd1);
        chk({tag, "_mres"},  64'(om_res),    64'(em_res));
        chk({tag, "_midx"},  64'(om_idx),    64'(em_idx));
        step();
        chk({tag, "_pulse"}, 64'(o13_valid), 64'd0);
    endtask

    logic [220:0] va, vb;
    logic [288:0] rv;
    logic [16:0]  sg, r1;
    logic [23:0]  h17 [0:999];
    logic [19:0]  h1  [0:999];

    initial begin
        int s, got, pulses, best;
        logic h;
        logic [7:0] bp;
        rst = 1'b1; hold = 1'b0;
        v13_valid = 0; vm_valid = 0; v1_valid = 0; v17_valid = 0;
        v13_vec = '0; vm_vec = '0; v1_vec = '0; v17_vec = '0;
        step(); step();
        chk("rst_valid", 64'(o13_valid), 64'd0);
        chk("rst_res",   64'(o13_res),   64'd0);
        chk("rst_idx",   64'(o13_idx),   64'd0);
        chk("rst_hit",   64'(o13_hit),   64'd0);
        chk("rst_v1",    64'(o1_valid),  64'd0);
        chk("rst_v17",   64'(o17_valid), 64'd0);
        rst = 1'b0;
        step();

        va = '0; va[3*17 +: 17] = seg(1, 8'h40, 8'h11); va[9*17 +: 17] = seg(1, 8'h80, 8'h22);
        run13("two_hit", va, va, 17'h18022, 4'd9, 17'h14011, 4'd3);

        va = '0; va[5*17 +: 17] = seg(1, 8'h55, 8'h05); va[6*17 +: 17] = seg(1, 8'h55, 8'h06);
        vb = '0; vb[5*17 +: 17] = seg(1, 8'h10, 8'h05); vb[6*17 +: 17] = seg(1, 8'h05, 8'h06);
        run13("tie", va, vb, 17'h15505, 4'd5, 17'h10506, 4'd6);

        va = '0; va[12*17 +: 17] = seg(1, 8'h01, 8'h0C);
        run13("odd", va, va, 17'h1010C, 4'd12, 17'h1010C, 4'd12);

        va = '0; va[0 +: 17] = seg(0, 8'h33, 8'h44);
        run13("nohit", va, va, 17'h03344, 4'd0, 17'h03344, 4'd0);

        // Streaming with a 3-cycle hold; the driver re-presents the stalled search.
        s = 0; got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            h = (cyc >= 5 && cyc < 8);
            hold = h;
            va = '0;
            va[12*17 +: 17] = seg(1, 8'h08, 8'hEE);
            if (s < 8) va[s*17 +: 17] = seg(1, 8'(8'h10 + s), 8'(8'hA0 + s));
            v13_vec = va;
            v13_valid = (s < 8);
            step();
            if (!h) begin
                if (s < 8) s++;
                if (o13_valid) begin
                    chk("b2b_idx", 64'(o13_idx), 64'(got));
                    chk("b2b_res", 64'(o13_res), 64'(seg(1, 8'(8'h10 + got), 8'(8'hA0 + got))));
                    got++;
                end
            end else begin
                chk("hold_valid", 64'(o13_valid), 64'(got > 0));
                chk("hold_idx", 64'(o13_idx), 64'(got - 1));
            end
        end
        chk("b2b_count", 64'(got), 64'd8);
        hold = 1'b0; v13_valid = 1'b0;

        // Reset lands on the third search; nothing in flight may surface.
        for (int c = 0; c < 3; c++) begin
            va = '0; va[c*17 +: 17] = seg(1, 8'h30, 8'(c));
            v13_vec = va; v13_valid = 1'b1; rst = (c == 2);
            step();
        end
        v13_valid = 1'b0; rst = 1'b0;
        chk("midrst_valid", 64'(o13_valid), 64'd0);
        chk("midrst_res",   64'(o13_res),   64'd0);
        chk("midrst_idx",   64'(o13_idx),   64'd0);
        chk("midrst_hit",   64'(o13_hit),   64'd0);
        pulses = 0;
        repeat (6) begin
            step();
            if (o13_valid) pulses++;
        end
        chk("midrst_nopulse", 64'(pulses), 64'd0);

        va = '0; va[0 +: 17] = seg(1, 8'h20, 8'h01); va[17 +: 17] = seg(1, 8'h21, 8'h02);
        run13("fresh", va, va, 17'h12102, 4'd1, 17'h12001, 4'd0);

        // Random sweep on NSEG=17 (latency 6) and NSEG=1 (latency 1) against an argmax model.
        v13_vec = '0; vm_vec = '0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 17; i++)
                rv[i*17 +: 17] = seg(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                                     8'($urandom_range(0, 255)));
            v17_vec = rv;
            v17_valid = 1'($urandom_range(0, 1));
            best = -1; bp = '0;
            for (int i = 0; i < 17; i++) begin
                sg = rv[i*17 +: 17];
                if (sg[16] && (best < 0 || sg[15:8] > bp)) begin
                    best = i; bp = sg[15:8];
                end
            end
            sg = rv[16:0];
            if (best >= 0) sg = rv[best*17 +: 17];
            h17[k] = {v17_valid, v17_valid & (best >= 0), 5'((best < 0) ? 0 : best), sg};

            r1 = seg(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            v1_vec = r1;
            v1_valid = 1'($urandom_range(0, 1));
            h1[k] = {v1_valid, v1_valid & r1[16], 1'b0, r1};

            step();
            chk("sweep17", 64'({o17_valid, o17_hit, o17_idx, o17_res}), (k >= 5) ? 64'(h17[k-5]) : 64'd0);
            chk("sweep1",  64'({o1_valid, o1_hit, o1_idx, o1_res}), 64'(h1[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/compr_tree_pipe.md
Name: compr_tree_pipe

Overview:
- Parametrised successor to the fixed 13-segment, 10-bit compare pipeline.
- Reduces NSEG match segments from the TCAM segment memories to a single winner through a registered binary tree.
- Each segment is {match, priority, rule ID}. The winner is the highest-ranked matching segment; its segment index is also reported.
- Adds valid tracking, a global pipeline hold, a selectable min/max priority order and a defined odd-node pass-through. Sits between the segment memories and the rule-result/action lookup.

Parameters:
NSEG, 13, number of input segments (>=1)
IDWID, 8, rule ID width
PRIWID, 8, rule priority width
PRIO_MAX, 1, 1 = numerically larger priority wins; 0 = smaller wins
SEGW, 1+PRIWID+IDWID, segment width (derived; do not override)
IXW, max(1,clog2(NSEG)), winner-index width (derived)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
i_Valid  input  1  i_Seg_Vector holds a valid search result this cycle
i_Hold  input  1  freeze entire pipeline (registers and valids hold)
i_Seg_Vector  input  NSEG*SEGW  segment k at [k*SEGW +: SEGW]; per segment: bit SEGW-1 = match, next PRIWID bits = priority, low IDWID bits = ID
o_Valid  output  1  o_Compare_Result / o_Win_Index valid
o_Compare_Result  output  SEGW  winning segment, same packing as input
o_Win_Index  output  IXW  index k of the winning input segment
o_Hit  output  1  equals o_Compare_Result match bit, qualified by o_Valid

Behaviour:
- Reset: synchronous and active-high. On rst=1 at a rising clk, every pipeline register, every valid bit and every index register clears to 0. All outputs read 0 the following cycle.
- rst has priority over i_Hold.
- Stage 0 registers i_Seg_Vector and i_Valid. Per-segment index k is attached as a constant.
- Tree structure:
  - L = clog2(NSEG) levels; each level is followed by a register.
  - Level n pairs node 2j with node 2j+1.
  - An odd last node passes through unchanged with its index, rather than comparing with itself.
- Latency is L+1 cycles from i_Valid sampled (not held) to o_Valid. NSEG=13 gives 5 cycles. NSEG=1 gives 1 cycle, with index 0.
- Node compare (left = lower index), in order:
  1. Exactly one operand has match=1: that operand wins.
  2. Both have match=1: the better priority wins per PRIO_MAX.
  3. Equal priority: left wins.
  4. Neither matches: left wins. Its data propagates, with match=0.
- No-hit result: o_Hit=0 and o_Compare_Result is the index-0 segment with match=0. o_Win_Index is 0.
- Throughput is one search per cycle when i_Hold=0. The valid bit travels with data through each stage.
- i_Hold=1:
  - All stage registers and valids hold their values.
  - i_Valid and i_Seg_Vector are ignored (not captured).
  - Outputs stay stable, and o_Valid remains as it was.
- Invalid slots (valid=0) still propagate data. Only o_Valid qualifies the outputs.
- Reset asserted mid-search discards all in-flight searches. No o_Valid pulse may appear for a search sampled before reset.
- Arithmetic: priority compare is unsigned, PRIWID bits. Indices are unsigned, IXW bits. No wrap effects.

Decomposition:
- Shared package compr_pkg holds:
  - the clog2 constant function
  - field offset constants (MATCH_BIT, PRIO_LSB, ID_LSB) derived from IDWID/PRIWID
- Sub-module compr_node is purely combinational.
  - Inputs: two segments plus two indices, with parameter PRIO_MAX.
  - Outputs: the winning segment and its index.
  - Instantiated per pair by generate loops over levels.
- Pass-through for odd nodes is done in the generate loop, not in compr_node.

Test Plan:
- NSEG=13, PRIO_MAX=1. Seg3={1,0x40,0x11}, seg9={1,0x80,0x22}, others match=0, i_Valid=1 for one cycle. Expect: o_Valid=1 exactly 5 cycles later, o_Compare_Result={1,0x80,0x22}, o_Win_Index=9, o_Hit=1.
- Tie: seg5 and seg6 both {1,0x55,...}. Expect: o_Win_Index=5. Rerun with PRIO_MAX=0 and seg5 prio 0x10, seg6 prio 0x05. Expect: index 6.
- Odd pass-through: only seg12 (last, unpaired) matches with prio 0x01. Expect: o_Win_Index=12, o_Hit=1. All match=0 gives o_Hit=0 and o_Win_Index=0.
- Back-to-back: 8 consecutive valid searches with distinct winners. Expect: 8 consecutive o_Valid cycles with results in order. Then assert i_Hold for 3 cycles mid-stream. Expect: outputs frozen during hold, no results lost or duplicated, and order preserved after release.
- Reset mid-flight: issue 3 searches, assert rst at cycle 2 for 1 cycle. Expect: all outputs 0 the next cycle and no o_Valid pulse for those searches. A fresh search afterwards completes with latency 5.
- Parameter sweep: NSEG=1, 2, 16, 17 with random vectors against a reference model (argmax, lowest-index tie-break). Expect: latency 1/2/5/6 and exact match on 10k vectors each.
